// File: rtl/fifo8x9_ctrl.sv
// fifo8x9_ctrl: control stage for the 8x9 FIFO storage block.
// Turns producer push / consumer pop requests into storage write/read
// enables and pointer increment/clear strobes. Keeps shadow pointers and an
// occupancy count, flags full/empty/almost-full and sticky overflow/underflow,
// and produces out_valid aligned with the storage block's registered DataOut.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | one cycle after reset; clears storage pointers, no traffic
// ST_RUN   | normal operation; push/pop accepted subject to full/empty
// ST_FLUSH | clears storage pointers; held while flush_i stays high
module fifo8x9_ctrl #(
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 4,
  parameter int AF_LEVEL = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  output logic             push_ready_o,
  input  logic             pop_i,
  output logic             out_valid_o,
  output logic             wren_o,
  output logic             wr_inc_o,
  output logic             wr_ptr_clr_o,
  output logic             rden_o,
  output logic             rd_inc_o,
  output logic             rd_ptr_clr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               out_valid_q, out_valid_d;

  logic               run;
  logic               full;
  logic               empty;
  logic               push_ready;
  logic               wr_acc;
  logic               rd_acc;
  logic               wr_last;
  logic               rd_last;

  // Status decoded from registered count only, so pop never reaches push_ready.
  always_comb begin
    run        = (state_q == ST_RUN);
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    push_ready = run & ~full;
    wr_acc     = push_i & push_ready;
    rd_acc     = run & pop_i & ~empty;
    wr_last    = (wptr_q == PTR_LAST);
    rd_last    = (rptr_q == PTR_LAST);
  end

  // Next-state and storage control decode.
  always_comb begin
    state_d      = state_q;
    wren_o       = 1'b0;
    wr_inc_o     = 1'b0;
    wr_ptr_clr_o = 1'b0;
    rden_o       = 1'b0;
    rd_inc_o     = 1'b0;
    rd_ptr_clr_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        wr_ptr_clr_o = 1'b1;
        rd_ptr_clr_o = 1'b1;
        state_d      = flush_i ? ST_FLUSH : ST_RUN;
      end
      ST_RUN: begin
        // The storage pointer is cleared instead of incremented on the last
        // slot so it never runs past the array.
        wren_o       = wr_acc;
        wr_inc_o     = wr_acc & ~wr_last;
        wr_ptr_clr_o = wr_acc & wr_last;
        rden_o       = rd_acc;
        rd_inc_o     = rd_acc & ~rd_last;
        rd_ptr_clr_o = rd_acc & rd_last;
        if (flush_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        wr_ptr_clr_o = 1'b1;
        rd_ptr_clr_o = 1'b1;
        state_d      = flush_i ? ST_FLUSH : ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Count, shadow pointers and sticky errors; entering FLUSH wipes them all.
  always_comb begin
    count_d     = count_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    ovf_d       = ovf_q | (run & push_i & ~push_ready);
    unf_d       = unf_q | (run & pop_i & empty);
    out_valid_d = rd_acc;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (wr_acc) wptr_d = wr_last ? '0 : wptr_q + PTR_W'(1);
    if (rd_acc) rptr_d = rd_last ? '0 : rptr_q + PTR_W'(1);
    if (state_d == ST_FLUSH) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end
  end

  // State and datapath registers. out_valid survives a flush: data already read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Status outputs.
  always_comb begin
    push_ready_o  = push_ready;
    out_valid_o   = out_valid_q;
    count_o       = count_q;
    full_o        = full;
    empty_o       = empty;
    almost_full_o = (count_q >= CNT_W'(AF_LEVEL));
    overflow_o    = ovf_q;
    underflow_o   = unf_q;
  end

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Bench for fifo8x9_ctrl: the DUT drives a behavioural model of the 8x9
// storage block; a queue-based reference model predicts status, control
// strobes and the data order seen on out_valid.
module tb_fifo8x9_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_i = 1'b0;
  logic       push_i = 1'b0;
  logic       pop_i = 1'b0;
  logic       push_ready_o, out_valid_o;
  logic       wren_o, wr_inc_o, wr_ptr_clr_o;
  logic       rden_o, rd_inc_o, rd_ptr_clr_o;
  logic [3:0] count_o;
  logic       full_o, empty_o, almost_full_o, overflow_o, underflow_o;
  logic [8:0] din = '0;

  int n_vec = 0;
  int n_err = 0;

  fifo8x9_ctrl #(.DEPTH(8), .CNT_W(4), .AF_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .push_i(push_i), .push_ready_o(push_ready_o),
    .pop_i(pop_i), .out_valid_o(out_valid_o),
    .wren_o(wren_o), .wr_inc_o(wr_inc_o), .wr_ptr_clr_o(wr_ptr_clr_o),
    .rden_o(rden_o), .rd_inc_o(rd_inc_o), .rd_ptr_clr_o(rd_ptr_clr_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  // Storage block model: 8-bit pointers, registered read data.
  logic [7:0] s_wp, s_rp;
  logic [8:0] mem [0:255];
  logic [8:0] s_dout;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_wp <= '0;
      s_rp <= '0;
    end else begin
      if (wren_o) mem[s_wp] <= din;
      if (rden_o) s_dout <= mem[s_rp];
      if (wr_ptr_clr_o) s_wp <= '0; else if (wr_inc_o) s_wp <= s_wp + 8'd1;
      if (rd_ptr_clr_o) s_rp <= '0; else if (rd_inc_o) s_rp <= s_rp + 8'd1;
    end
  end

  // Reference model: mode 0=init 1=run 2=flush.
  int         m_mode;
  logic [8:0] m_q[$];
  bit         m_ovf, m_unf, m_pv;
  logic [8:0] m_pd;
  int         m_wn, m_rn;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    m_ovf = 0; m_unf = 0; m_pv = 0;
    m_wn = 0; m_rn = 0;
  endtask

  task automatic step(input bit p, input bit r, input bit f, input logic [8:0] d);
    int sz;
    bit run, wacc, racc;
    @(negedge clk);
    push_i = p; pop_i = r; flush_i = f; din = d;
    #1;
    sz   = m_q.size();
    run  = (m_mode == 1);
    wacc = run && p && sz < 8;
    racc = run && r && sz > 0;
    check_eq("count", 16'(count_o), 16'(sz));
    check_eq("empty", 16'(empty_o), 16'(sz == 0));
    check_eq("full", 16'(full_o), 16'(sz == 8));
    check_eq("almost_full", 16'(almost_full_o), 16'(sz >= 6));
    check_eq("overflow", 16'(overflow_o), 16'(m_ovf));
    check_eq("underflow", 16'(underflow_o), 16'(m_unf));
    check_eq("out_valid", 16'(out_valid_o), 16'(m_pv));
    if (m_pv) check_eq("data", 16'(s_dout), 16'(m_pd));
    check_eq("push_ready", 16'(push_ready_o), 16'(run && sz < 8));
    check_eq("wren", 16'(wren_o), 16'(wacc));
    check_eq("wr_inc", 16'(wr_inc_o), 16'(wacc && m_wn != 7));
    check_eq("wr_ptr_clr", 16'(wr_ptr_clr_o), 16'(!run || (wacc && m_wn == 7)));
    check_eq("rden", 16'(rden_o), 16'(racc));
    check_eq("rd_inc", 16'(rd_inc_o), 16'(racc && m_rn != 7));
    check_eq("rd_ptr_clr", 16'(rd_ptr_clr_o), 16'(!run || (racc && m_rn == 7)));
    @(posedge clk);
    m_pv = 0;
    case (m_mode)
      0, 2: m_mode = f ? 2 : 1;
      default: begin
        if (p && !wacc) m_ovf = 1;
        if (r && sz == 0) m_unf = 1;
        if (racc) begin
          m_pv = 1;
          m_pd = m_q.pop_front();
          m_rn = (m_rn + 1) % 8;
        end
        if (wacc) begin
          m_q.push_back(d);
          m_wn = (m_wn + 1) % 8;
        end
        if (f) begin
          m_mode = 2;
          m_q.delete();
          m_ovf = 0; m_unf = 0;
          m_wn = 0; m_rn = 0;
        end
      end
    endcase
  endtask

  task automatic async_reset();
    @(negedge clk);
    push_i = 0; pop_i = 0; flush_i = 0;
    rst = 1;
    #1;
    check_eq("rst_count", 16'(count_o), 16'd0);
    check_eq("rst_empty", 16'(empty_o), 16'd1);
    check_eq("rst_full", 16'(full_o), 16'd0);
    check_eq("rst_af", 16'(almost_full_o), 16'd0);
    check_eq("rst_out_valid", 16'(out_valid_o), 16'd0);
    check_eq("rst_overflow", 16'(overflow_o), 16'd0);
    check_eq("rst_underflow", 16'(underflow_o), 16'd0);
    check_eq("rst_push_ready", 16'(push_ready_o), 16'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    model_reset();
    async_reset();
    step(0, 0, 0, 9'h0);

    // Fill with overflow, then drain with underflow.
    for (int i = 1; i <= 9; i++) step(1, 0, 0, 9'(9'h100 + i));
    for (int i = 0; i < 9; i++) step(0, 1, 0, 9'h0);
    step(0, 0, 0, 9'h0);

    // Pointer wrap with count held at 1.
    step(1, 0, 0, 9'(9'h0A0));
    for (int i = 1; i <= 10; i++) step(1, 1, 0, 9'(9'h0A0 + i));
    step(0, 1, 0, 9'h0);
    step(0, 0, 0, 9'h0);

    // Simultaneous push/pop at count 3 and at count 8.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 9'($urandom));
    step(1, 1, 0, 9'($urandom));
    for (int i = 0; i < 5; i++) step(1, 0, 0, 9'($urandom));
    step(1, 1, 0, 9'($urandom));

    // Flush mid-stream with a pop accepted in the flush cycle.
    step(0, 1, 0, 9'h0);
    step(0, 1, 0, 9'h0);
    step(0, 1, 1, 9'h0);
    step(0, 0, 0, 9'h0);
    step(1, 0, 0, 9'($urandom));

    // Flush held for several cycles.
    step(0, 0, 1, 9'h0);
    step(0, 0, 1, 9'h0);
    step(0, 0, 0, 9'h0);

    // Randomised traffic in push-biased and pop-biased blocks.
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 40; i++) begin
        bit p, r, f;
        p = ($urandom_range(0, 99) < ((b % 2 == 0) ? 75 : 30));
        r = ($urandom_range(0, 99) < ((b % 2 == 0) ? 30 : 75));
        f = ($urandom_range(0, 99) < 2);
        step(p, r, f, 9'($urandom));
      end
    end

    // Reset mid-traffic with count 5 and a read in flight.
    step(0, 0, 1, 9'h0);
    step(0, 0, 0, 9'h0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 9'($urandom));
    step(0, 1, 0, 9'h0);
    async_reset();
    step(0, 0, 0, 9'h0);
    step(1, 0, 0, 9'h1AB);
    step(0, 1, 0, 9'h0);
    step(0, 0, 0, 9'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo8x9_ctrl.md
Name: fifo8x9_ctrl

Overview:
Control stage that sits directly upstream of the 8-entry x 9-bit FIFO storage block and drives all of its control inputs: write enable, write-pointer increment and clear, read enable, read-pointer increment and clear. It converts producer push and consumer pop requests into those signals. It keeps shadow pointers and an occupancy count, flags full, empty and almost-full, and reports sticky overflow and underflow errors. It also generates a valid strobe aligned with the FIFO's registered data output.

Parameters:
DEPTH, 8, number of FIFO entries; must match the storage block; shadow pointer width is clog2(DEPTH)
CNT_W, 4, width of the occupancy count; holds 0..DEPTH
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous request to empty the FIFO
push  in  1  producer write request; DataIn is supplied directly to the storage block
push_ready  out  1  write accepted this cycle if push=1
pop  in  1  consumer read request
out_valid  out  1  storage DataOut is valid this cycle; one-cycle pulse
wren  out  1  to storage write enable
wr_inc  out  1  to storage write-pointer increment
wr_ptr_clr  out  1  to storage write-pointer clear
rden  out  1  to storage read enable
rd_inc  out  1  to storage read-pointer increment
rd_ptr_clr  out  1  to storage read-pointer clear
count  out  CNT_W  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
overflow  out  1  sticky: push attempted while push_ready=0 in RUN
underflow  out  1  sticky: pop attempted while empty in RUN

Behaviour:
- States: INIT, RUN, FLUSH. rst forces INIT.
- INIT lasts exactly 1 cycle, then goes to RUN, or to FLUSH if flush=1.
- INIT and FLUSH drive wr_ptr_clr=rd_ptr_clr=1. In these states wren, wr_inc, rden and rd_inc are 0, push_ready=0, and pop is ignored.
- RUN goes to FLUSH on a clk edge where flush=1; push and pop in that same cycle are still honoured.
- FLUSH lasts 1 cycle, then returns to RUN, or stays in FLUSH while flush=1.
- On entering FLUSH: count=0, shadow pointers=0, overflow=underflow=0.
- Reset values: count=0, empty=1, full=0, almost_full=0, out_valid=0, overflow=0, underflow=0, shadow pointers=0. Control outputs follow the INIT decode.
- Write acceptance (RUN only): wr_acc = push & push_ready, where push_ready = (state==RUN) & ~full. full is decoded from registered count, so no combinational path from pop to push_ready.
- Read acceptance (RUN only): rd_acc = pop & ~empty.
- On wr_acc: wren=1 in the same cycle.
  - If shadow wptr < DEPTH-1: wr_inc=1.
  - If shadow wptr == DEPTH-1: wr_ptr_clr=1 and wr_inc=0. This wraps the storage 8-bit pointer before it exceeds the array.
  - Shadow wptr wraps modulo DEPTH.
- On rd_acc: rden=1 in the same cycle, with the same wrap rule applied to rd_inc, rd_ptr_clr and shadow rptr.
- Read latency: out_valid=1 exactly one cycle after rd_acc, because storage DataOut is registered. out_valid=0 otherwise, when DataOut is high impedance.
- out_valid still fires if FLUSH is entered on the edge after rd_acc, since the data was already read.
- count update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - both, or neither: unchanged.
- Simultaneous push and pop:
  - When empty: push accepted, pop rejected, underflow set.
  - When full: pop accepted, push rejected, overflow set.
- Error flags set only in RUN. They are cleared only by rst or by entering FLUSH.
- count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset and init: assert rst mid-traffic with count=5 -> count=0, empty=1, out_valid=0 immediately. First cycle after release is INIT: wr_ptr_clr=rd_ptr_clr=1, push_ready=0. RUN follows next cycle.
- Fill and overflow: 9 consecutive pushes of 0x101..0x109 -> the first 8 are accepted, count=8, full=1, almost_full from the 6th accept. The 9th has push_ready=0, wren=0, overflow=1.
- Drain order: pop 8 times, then pop once more -> rden pulses 8 times, out_valid 8 times each one cycle later, data 0x101..0x108 in order. The 9th pop sets underflow=1 with rden=0; empty=1.
- Pointer wrap: 10 push/pop pairs with count held at 1 -> on the 8th write, wr_ptr_clr=1 and wr_inc=0. Read wrap occurs likewise one cycle later. Data is returned in order with no gaps.
- Simultaneous ops: at count=3, push and pop in the same cycle -> wren=rden=1, count stays 3. At count=8, the same -> only the pop is accepted and overflow=1.
- Flush mid-stream: count=5 with a pop accepted, flush=1 for 1 cycle -> out_valid pulses the next cycle, FLUSH asserts both clears, count=0, errors cleared. Back in RUN, push_ready=1.
